// File: rtl/sc_grid_classifier_pkg.sv
// Shared types and constants for the mains grid classifier: debounced grid
// state, per-sample class, and the measurement LSB scalings.
package sc_grid_classifier_pkg;

  typedef enum logic [1:0] {
    GRID_NORMAL   = 2'd0,
    GRID_UNSTABLE = 2'd1,
    GRID_CRITICAL = 2'd2
  } grid_state_t;

  typedef enum logic [1:0] {
    CLS_NORM = 2'd0,
    CLS_UNST = 2'd1,
    CLS_CRIT = 2'd2
  } sample_class_t;

  // Voltage LSB is 0.1 V (100 mV); frequency LSB is 0.01 Hz (10 mHz).
  localparam int V_LSB_MV  = 100;
  localparam int F_LSB_MHZ = 10;

  localparam int V_W = 12;
  localparam int F_W = 13;

endpackage

// File: rtl/sc_band_cmp.sv
// Combinational per-sample classifier: places one (v_rms, freq) pair into
// the critical, normal or unstable class using unsigned band compares.
module sc_band_cmp
  import sc_grid_classifier_pkg::*;
#(
  parameter int V_NORM_LO = 2070,
  parameter int V_NORM_HI = 2530,
  parameter int V_CRIT_LO = 1800,
  parameter int V_CRIT_HI = 2760,
  parameter int F_NORM_LO = 4950,
  parameter int F_NORM_HI = 5050,
  parameter int F_CRIT_LO = 4800,
  parameter int F_CRIT_HI = 5200
) (
  input  logic [V_W-1:0] v_rms,
  input  logic [F_W-1:0] freq,
  output sample_class_t  sample_class
);

  localparam logic [V_W-1:0] VNL = V_W'(V_NORM_LO);
  localparam logic [V_W-1:0] VNH = V_W'(V_NORM_HI);
  localparam logic [V_W-1:0] VCL = V_W'(V_CRIT_LO);
  localparam logic [V_W-1:0] VCH = V_W'(V_CRIT_HI);
  localparam logic [F_W-1:0] FNL = F_W'(F_NORM_LO);
  localparam logic [F_W-1:0] FNH = F_W'(F_NORM_HI);
  localparam logic [F_W-1:0] FCL = F_W'(F_CRIT_LO);
  localparam logic [F_W-1:0] FCH = F_W'(F_CRIT_HI);

  logic is_crit;
  logic is_norm;

  assign is_crit = (v_rms < VCL) || (v_rms > VCH) || (freq < FCL) || (freq > FCH);
  assign is_norm = (v_rms >= VNL) && (v_rms <= VNH) && (freq >= FNL) && (freq <= FNH);

  always_comb begin
    sample_class = CLS_UNST;
    if (is_crit) begin
      sample_class = CLS_CRIT;
    end else if (is_norm) begin
      sample_class = CLS_NORM;
    end
  end

endmodule

// File: rtl/sc_grid_classifier.sv
// Debounced mains classifier: consecutive-sample hysteresis counters drive
// the grid state, and a sample watchdog forces CRITICAL on sensor loss.
module sc_grid_classifier
  import sc_grid_classifier_pkg::*;
#(
  parameter int V_NORM_LO   = 2070,
  parameter int V_NORM_HI   = 2530,
  parameter int V_CRIT_LO   = 1800,
  parameter int V_CRIT_HI   = 2760,
  parameter int F_NORM_LO   = 4950,
  parameter int F_NORM_HI   = 5050,
  parameter int F_CRIT_LO   = 4800,
  parameter int F_CRIT_HI   = 5200,
  parameter int UNST_CNT    = 4,
  parameter int CRIT_CNT    = 2,
  parameter int RECOVER_CNT = 16,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           sample_valid,
  input  logic [V_W-1:0] v_rms,
  input  logic [F_W-1:0] freq,
  output grid_state_t    grid_state,
  output logic           state_chg,
  output logic           sensor_timeout
);

  localparam int CW = $clog2(CRIT_CNT + 1);
  localparam int BW = $clog2(UNST_CNT + 1);
  localparam int GW = $clog2(RECOVER_CNT + 1);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [CW-1:0] CRIT_MAX = CW'(CRIT_CNT);
  localparam logic [BW-1:0] BAD_MAX  = BW'(UNST_CNT);
  localparam logic [GW-1:0] GOOD_MAX = GW'(RECOVER_CNT);
  localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT_CYC);

  sample_class_t sample_class;

  grid_state_t   state_nxt;
  logic          timeout_nxt;
  logic [CW-1:0] crit_cnt, crit_nxt, crit_inc;
  logic [BW-1:0] bad_cnt, bad_nxt, bad_inc;
  logic [GW-1:0] good_cnt, good_nxt, good_inc;
  logic [WW-1:0] wd_cnt, wd_nxt;

  sc_band_cmp #(
    .V_NORM_LO(V_NORM_LO), .V_NORM_HI(V_NORM_HI),
    .V_CRIT_LO(V_CRIT_LO), .V_CRIT_HI(V_CRIT_HI),
    .F_NORM_LO(F_NORM_LO), .F_NORM_HI(F_NORM_HI),
    .F_CRIT_LO(F_CRIT_LO), .F_CRIT_HI(F_CRIT_HI)
  ) u_band_cmp (
    .v_rms       (v_rms),
    .freq        (freq),
    .sample_class(sample_class)
  );

  // Saturating increments; a counter parked at its threshold stays there.
  always_comb begin
    crit_inc = (crit_cnt == CRIT_MAX) ? crit_cnt : crit_cnt + CW'(1);
    bad_inc  = (bad_cnt  == BAD_MAX)  ? bad_cnt  : bad_cnt  + BW'(1);
    good_inc = (good_cnt == GOOD_MAX) ? good_cnt : good_cnt + GW'(1);
  end

  always_comb begin
    state_nxt   = grid_state;
    timeout_nxt = sensor_timeout;
    crit_nxt    = crit_cnt;
    bad_nxt     = bad_cnt;
    good_nxt    = good_cnt;
    wd_nxt      = wd_cnt;

    if (sample_valid) begin
      wd_nxt      = '0;
      timeout_nxt = 1'b0;
      case (sample_class)
        CLS_CRIT: begin
          crit_nxt = crit_inc;
          bad_nxt  = bad_inc;
          good_nxt = '0;
        end
        CLS_UNST: begin
          crit_nxt = '0;
          bad_nxt  = bad_inc;
          good_nxt = '0;
        end
        default: begin
          crit_nxt = '0;
          bad_nxt  = '0;
          good_nxt = good_inc;
        end
      endcase

      // CRITICAL has no direct exit to UNSTABLE; only full recovery leaves it.
      if (crit_nxt == CRIT_MAX) begin
        state_nxt = GRID_CRITICAL;
      end else if (grid_state == GRID_NORMAL && bad_nxt == BAD_MAX) begin
        state_nxt = GRID_UNSTABLE;
      end else if (grid_state != GRID_NORMAL && good_nxt == GOOD_MAX) begin
        state_nxt = GRID_NORMAL;
      end

      if (state_nxt != grid_state) begin
        crit_nxt = '0;
        bad_nxt  = '0;
        good_nxt = '0;
      end
    end else if (wd_cnt != WD_MAX) begin
      wd_nxt = wd_cnt + WW'(1);
      if (wd_nxt == WD_MAX) begin
        state_nxt   = GRID_CRITICAL;
        timeout_nxt = 1'b1;
        crit_nxt    = '0;
        bad_nxt     = '0;
        good_nxt    = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      grid_state     <= GRID_UNSTABLE;
      state_chg      <= 1'b0;
      sensor_timeout <= 1'b0;
      crit_cnt       <= '0;
      bad_cnt        <= '0;
      good_cnt       <= '0;
      wd_cnt         <= '0;
    end else begin
      grid_state     <= state_nxt;
      state_chg      <= (state_nxt != grid_state);
      sensor_timeout <= timeout_nxt;
      crit_cnt       <= crit_nxt;
      bad_cnt        <= bad_nxt;
      good_cnt       <= good_nxt;
      wd_cnt         <= wd_nxt;
    end
  end

endmodule

// File: tb/tb_sc_grid_classifier.sv
// Directed bench for sc_grid_classifier: hysteresis, band edges, watchdog
// and reset behaviour, each checked against hand-computed states.
module tb_sc_grid_classifier;
  import sc_grid_classifier_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        sample_valid;
  logic [11:0] v_rms;
  logic [12:0] freq;
  grid_state_t grid_state;
  logic        state_chg;
  logic        sensor_timeout;

  int n_cmp;
  int n_err;

  sc_grid_classifier dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sample_valid  (sample_valid),
    .v_rms         (v_rms),
    .freq          (freq),
    .grid_state    (grid_state),
    .state_chg     (state_chg),
    .sensor_timeout(sensor_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle with the given inputs; returns 1 ns after the edge.
  task automatic cyc(input logic vld, input logic [11:0] v, input logic [12:0] f);
    sample_valid = vld;
    v_rms        = v;
    freq         = f;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    cyc(1'b1, 12'd2300, 13'd5000);
    cyc(1'b0, 12'd0, 13'd0);
    n_cmp++;
    if (grid_state !== GRID_UNSTABLE || state_chg !== 1'b0 || sensor_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL reset: state=%0d chg=%0b to=%0b, required state=%0d chg=0 to=0",
               grid_state, state_chg, sensor_timeout, GRID_UNSTABLE);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_startup_normal;
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 12'd2300, 13'd5000);
      n_cmp++;
      if (grid_state !== ((i == 16) ? GRID_NORMAL : GRID_UNSTABLE) || state_chg !== (i == 16)) begin
        n_err++;
        $display("FAIL startup sample %0d: state=%0d chg=%0b", i, grid_state, state_chg);
      end
    end
    cyc(1'b0, 12'd0, 13'd0);
    n_cmp++;
    if (state_chg !== 1'b0 || grid_state !== GRID_NORMAL) begin
      n_err++;
      $display("FAIL startup pulse width: chg=%0b state=%0d, required chg=0 state=0", state_chg, grid_state);
    end
  endtask

  task automatic recover_normal(input string tag);
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 12'd2300, 13'd5000);
    end
    n_cmp++;
    if (grid_state !== GRID_NORMAL || state_chg !== 1'b1) begin
      n_err++;
      $display("FAIL %s recovery: state=%0d chg=%0b, required state=0 chg=1", tag, grid_state, state_chg);
    end
  endtask

  task automatic test_unstable;
    for (int i = 0; i < 3; i++) cyc(1'b1, 12'd2600, 13'd5000);
    cyc(1'b1, 12'd2300, 13'd5000);
    n_cmp++;
    if (grid_state !== GRID_NORMAL) begin
      n_err++;
      $display("FAIL unstable first burst: state=%0d, required 0", grid_state);
    end
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, 12'd2600, 13'd5000);
      n_cmp++;
      if (grid_state !== ((i == 4) ? GRID_UNSTABLE : GRID_NORMAL) || state_chg !== (i == 4)) begin
        n_err++;
        $display("FAIL unstable second burst %0d: state=%0d chg=%0b", i, grid_state, state_chg);
      end
    end
    recover_normal("unstable");
  endtask

  task automatic test_critical;
    cyc(1'b1, 12'd1700, 13'd5000);
    n_cmp++;
    if (grid_state !== GRID_NORMAL) begin
      n_err++;
      $display("FAIL critical first sample: state=%0d, required 0", grid_state);
    end
    cyc(1'b1, 12'd2300, 13'd4700);
    n_cmp++;
    if (grid_state !== GRID_CRITICAL || state_chg !== 1'b1) begin
      n_err++;
      $display("FAIL critical entry: state=%0d chg=%0b, required state=2 chg=1", grid_state, state_chg);
    end
    for (int i = 0; i < 15; i++) cyc(1'b1, 12'd2300, 13'd5000);
    cyc(1'b1, 12'd2600, 13'd5000);
    n_cmp++;
    if (grid_state !== GRID_CRITICAL) begin
      n_err++;
      $display("FAIL critical latch on unstable: state=%0d, required 2", grid_state);
    end
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 12'd2300, 13'd5000);
      n_cmp++;
      if (grid_state !== ((i == 16) ? GRID_NORMAL : GRID_CRITICAL)) begin
        n_err++;
        $display("FAIL critical recovery sample %0d: state=%0d", i, grid_state);
      end
    end
  endtask

  task automatic test_boundaries;
    for (int i = 0; i < 4; i++) cyc(1'b1, 12'd2070, 13'd4950);
    for (int i = 0; i < 4; i++) cyc(1'b1, 12'd2530, 13'd5050);
    n_cmp++;
    if (grid_state !== GRID_NORMAL) begin
      n_err++;
      $display("FAIL boundary normal edges: state=%0d, required 0", grid_state);
    end
    cyc(1'b1, 12'd1800, 13'd5000);
    cyc(1'b1, 12'd1800, 13'd5000);
    n_cmp++;
    if (grid_state !== GRID_NORMAL) begin
      n_err++;
      $display("FAIL boundary 1800 not critical: state=%0d, required 0", grid_state);
    end
    cyc(1'b1, 12'd1800, 13'd5000);
    cyc(1'b1, 12'd1800, 13'd5000);
    n_cmp++;
    if (grid_state !== GRID_UNSTABLE) begin
      n_err++;
      $display("FAIL boundary 1800 unstable: state=%0d, required 1", grid_state);
    end
    recover_normal("boundary 1800");
    cyc(1'b1, 12'd1799, 13'd5000);
    cyc(1'b1, 12'd1799, 13'd5000);
    n_cmp++;
    if (grid_state !== GRID_CRITICAL) begin
      n_err++;
      $display("FAIL boundary 1799 critical: state=%0d, required 2", grid_state);
    end
    recover_normal("boundary 1799");
  endtask

  task automatic test_watchdog;
    for (int i = 0; i < 999; i++) cyc(1'b0, 12'd0, 13'd0);
    n_cmp++;
    if (grid_state !== GRID_NORMAL || sensor_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL watchdog early: state=%0d to=%0b, required state=0 to=0", grid_state, sensor_timeout);
    end
    cyc(1'b0, 12'd0, 13'd0);
    n_cmp++;
    if (grid_state !== GRID_CRITICAL || sensor_timeout !== 1'b1 || state_chg !== 1'b1) begin
      n_err++;
      $display("FAIL watchdog expiry: state=%0d to=%0b chg=%0b, required 2/1/1",
               grid_state, sensor_timeout, state_chg);
    end
    cyc(1'b0, 12'd0, 13'd0);
    n_cmp++;
    if (sensor_timeout !== 1'b1 || state_chg !== 1'b0) begin
      n_err++;
      $display("FAIL watchdog hold: to=%0b chg=%0b, required to=1 chg=0", sensor_timeout, state_chg);
    end
    cyc(1'b1, 12'd2300, 13'd5000);
    n_cmp++;
    if (sensor_timeout !== 1'b0 || grid_state !== GRID_CRITICAL) begin
      n_err++;
      $display("FAIL watchdog clear: to=%0b state=%0d, required to=0 state=2", sensor_timeout, grid_state);
    end
    for (int i = 2; i <= 16; i++) begin
      cyc(1'b1, 12'd2300, 13'd5000);
      n_cmp++;
      if (grid_state !== ((i == 16) ? GRID_NORMAL : GRID_CRITICAL)) begin
        n_err++;
        $display("FAIL watchdog recovery sample %0d: state=%0d", i, grid_state);
      end
    end
  endtask

  task automatic test_sample_wins;
    for (int i = 0; i < 999; i++) cyc(1'b0, 12'd0, 13'd0);
    cyc(1'b1, 12'd2300, 13'd5000);
    n_cmp++;
    if (sensor_timeout !== 1'b0 || grid_state !== GRID_NORMAL || state_chg !== 1'b0) begin
      n_err++;
      $display("FAIL sample at expiry: to=%0b state=%0d chg=%0b, required 0/0/0",
               sensor_timeout, grid_state, state_chg);
    end
  endtask

  task automatic test_reset_mid;
    cyc(1'b1, 12'd1799, 13'd5000);
    cyc(1'b1, 12'd1799, 13'd5000);
    for (int i = 0; i < 10; i++) cyc(1'b1, 12'd2300, 13'd5000);
    n_cmp++;
    if (grid_state !== GRID_CRITICAL) begin
      n_err++;
      $display("FAIL reset_mid setup: state=%0d, required 2", grid_state);
    end
    reset_n = 1'b0;
    cyc(1'b1, 12'd2300, 13'd5000);
    reset_n = 1'b1;
    n_cmp++;
    if (grid_state !== GRID_UNSTABLE || state_chg !== 1'b0 || sensor_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: state=%0d chg=%0b to=%0b, required 1/0/0",
               grid_state, state_chg, sensor_timeout);
    end
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 12'd2300, 13'd5000);
      n_cmp++;
      if (grid_state !== ((i == 16) ? GRID_NORMAL : GRID_UNSTABLE)) begin
        n_err++;
        $display("FAIL reset_mid recovery sample %0d: state=%0d", i, grid_state);
      end
    end
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    reset_n      = 1'b0;
    sample_valid = 1'b0;
    v_rms        = '0;
    freq         = '0;
    test_reset();
    test_startup_normal();
    test_unstable();
    test_critical();
    test_boundaries();
    test_watchdog();
    test_sample_wins();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
